// File: rtl/tone_period_meter.sv
// Tone period meter: measures a square wave's period in strobe ticks and sums 2^AVG_LOG2 periods per result.
// Latency: result registers 2 clk edges after tone_in is first sampled high on the completing period.
// Backpressure: valid holds until ready; a new result overwrites an unaccepted one and sets sticky overrun.
module tone_period_meter #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned AVG_LOG2 = 3,
  parameter int unsigned TIMEOUT  = 16'hFFFF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      strobe,
  input  logic                      tone_in,
  output logic [CNT_W+AVG_LOG2-1:0] period_sum,
  output logic                      period_valid,
  input  logic                      period_ready,
  output logic                      no_signal,
  output logic                      overrun
);

  localparam int unsigned SUM_W = CNT_W + AVG_LOG2;
  // One spare bit so the period counter is never zero-width.
  localparam int unsigned NPD_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [NPD_W-1:0] LAST_NPD  = NPD_W'((1 << AVG_LOG2) - 1);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  // Synchronizer and edge history
  logic s1_q;
  logic s2_q;
  logic s3_q;
  logic rise;

  // Measurement state
  state_t           state_q;
  logic [CNT_W-1:0] count_q;
  logic [SUM_W-1:0] acc_q;
  logic [NPD_W-1:0] npd_q;

  // Result and status registers
  logic [SUM_W-1:0] sum_q;
  logic             valid_q;
  logic             nosig_q;
  logic             ovr_q;

  // Combinational next values
  logic [SUM_W-1:0] closed_d;
  logic [SUM_W-1:0] acc_d;
  logic             last_d;
  logic             load_d;

  // Two-flop synchronizer followed by a history flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= tone_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

  // Closing period value: a strobe coincident with the edge belongs to the period being closed.
  always_comb begin
    closed_d = SUM_W'(count_q) + SUM_W'(strobe);
    acc_d    = acc_q + closed_d;
    last_d   = (npd_q == LAST_NPD);
    load_d   = (state_q == ST_MEASURE) && rise && last_d;
  end

  // Measurement FSM: lock on first edge, count strobes per period, accumulate, detect loss of signal.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      acc_q   <= '0;
      npd_q   <= '0;
      nosig_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          count_q <= '0;
          acc_q   <= '0;
          npd_q   <= '0;
          if (rise) begin
            state_q <= ST_MEASURE;
            nosig_q <= 1'b0;
          end
        end
        ST_MEASURE: begin
          if (rise) begin
            // Every edge restarts the tick count; the block boundary resets the accumulator.
            count_q <= '0;
            if (last_d) begin
              acc_q <= '0;
              npd_q <= '0;
            end else begin
              acc_q <= acc_d;
              npd_q <= npd_q + NPD_W'(1);
            end
          end else if (strobe) begin
            if (count_q == TIMEOUT_C) begin
              // Lost the tone: drop the partial block and wait for a fresh lock.
              state_q <= ST_IDLE;
              nosig_q <= 1'b1;
              count_q <= '0;
              acc_q   <= '0;
              npd_q   <= '0;
            end else begin
              count_q <= count_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Result register and handshake; a load always wins over an accept in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (load_d) begin
        sum_q   <= acc_d;
        valid_q <= 1'b1;
        if (valid_q && !period_ready) begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && period_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign period_sum   = sum_q;
  assign period_valid = valid_q;
  assign no_signal    = nosig_q;
  assign overrun      = ovr_q;

endmodule
